wb_queue: RTL



---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 75 +++++++
 rtl/wb_queue.sv | 110 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Writeback queue shared definitions.
// Purpose: default address/data widths and FIFO depth, the queued entry
//          layout, and the two arbiter priority encodings.
package wb_pkg;

  localparam int DEF_AW    = 5;
  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 4;

  // One pending register write: destination register and its data.
  typedef struct packed {
    logic [DEF_AW-1:0] dr;
    logic [DEF_DW-1:0] data;
  } wb_entry_t;

  // Round-robin priority encodings (state of the arbiter's priority flop).
  localparam logic [0:0] SRC_A = 1'b0;
  localparam logic [0:0] SRC_B = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries.
// Purpose: buffers accepted register writes in order and exposes which slots
//          are occupied (with their destination registers) for hazard checks.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   push, push_entry    enqueue request (ignored when full)
//   pop                 dequeue request (ignored when empty)
//   head                entry at the read pointer (stale when empty)
//   count, full, empty  occupancy status
//   occ                 one bit per storage slot, 1 = slot holds a live entry
//   occ_dr              destination register of every slot, slot i at [i*AW +: AW]
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           occ,
  output logic [DEPTH*DEF_AW-1:0]    occ_dr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] rel;
    assign rel                          = PW'(g) - rd_ptr;
    assign occ[g]                       = (CW'(rel) < count);
    assign occ_dr[g*DEF_AW +: DEF_AW]   = mem[g].dr;
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue in front of the register bank.
// Purpose: accepts register writes from two producers (A: ALU, B: load unit),
//          arbitrates round-robin, buffers them in order and drains one per
//          cycle into the bank; flags pending writes to the bank's read
//          addresses.
// Handshake: a source transfers at a rising edge when its valid and ready are
//          both 1. Ready never depends on the source's own valid; it depends
//          only on full, the priority flop and the other source's valid.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   a_valid/a_dr/a_data, a_ready        source A request / accept
//   b_valid/b_dr/b_data, b_ready        source B request / accept
//   wb_stall                            bank write port busy this cycle
//   write, dr, wdata                    bank write port (head of queue)
//   sr1, sr2 -> hz1, hz2                pending write to a bank read address
//   count, full, empty                  queue occupancy
// AW/DW must match the package widths used by wb_entry_t.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_valid,
  input  logic [AW-1:0]              a_dr,
  input  logic [DW-1:0]              a_data,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [AW-1:0]              b_dr,
  input  logic [DW-1:0]              b_data,
  output logic                       b_ready,
  input  logic                       wb_stall,
  output logic                       write,
  output logic [AW-1:0]              dr,
  output logic [DW-1:0]              wdata,
  input  logic [AW-1:0]              sr1,
  input  logic [AW-1:0]              sr2,
  output logic                       hz1,
  output logic                       hz2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  logic [0:0]          prio;
  logic                a_fire;
  logic                b_fire;
  wb_entry_t           push_entry;
  wb_entry_t           head;
  logic [DEPTH-1:0]    occ;
  logic [DEPTH*AW-1:0] occ_dr;

  // Arbiter: the source holding priority may always go (unless full); the
  // other one only when the priority holder is idle. Full blocks both even
  // if the head pops in the same cycle.
  assign a_ready = ~full & ((prio == SRC_A) | ~b_valid);
  assign b_ready = ~full & ((prio == SRC_B) | ~a_valid);
  assign a_fire  = a_valid & a_ready;
  assign b_fire  = b_valid & b_ready;

  always_comb begin
    push_entry = '0;
    if (a_fire) begin
      push_entry.dr   = a_dr;
      push_entry.data = a_data;
    end else begin
      push_entry.dr   = b_dr;
      push_entry.data = b_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      prio <= SRC_A;
    else if (a_fire) prio <= SRC_B;
    else if (b_fire) prio <= SRC_A;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (a_fire | b_fire),
    .push_entry (push_entry),
    .pop        (write),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .occ        (occ),
    .occ_dr     (occ_dr)
  );

  // Drain: the head is presented whenever present; it pops on a write edge.
  assign write = ~empty & ~wb_stall;
  assign dr    = empty ? '0 : head.dr;
  assign wdata = empty ? '0 : head.data;

  // Hazards cover every live entry, including the head being written now.
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && (occ_dr[i*AW +: AW] == sr1)) hz1 = 1'b1;
      if (occ[i] && (occ_dr[i*AW +: AW] == sr2)) hz2 = 1'b1;
    end
  end

endmodule
